// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the legal operand-width range.
package serial_add_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/full_add_cell.sv
// One-bit combinational full adder.
// Reused every cycle by the serial adder.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule : full_add_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder with valid/ready handshakes on both sides.
// Adds LSB first through one full_add_cell and a registered carry, taking WIDTH cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   bit_cnt;
  logic               fa_sum;
  logic               fa_co;

  full_add_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  assign sum = sum_sh;

  // NOTE: all state updates use <= so every register samples pre-edge values,
  // which keeps the shift/carry pipeline order-independent in simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, since sum/cout/ovf are
      // directly visible and must read zero after reset.
      state        <= IDLE;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      a_sh         <= '0;
      b_sh         <= '0;
      sum_sh       <= '0;
      carry        <= 1'b0;
      cout         <= 1'b0;
      ovf          <= 1'b0;
      bit_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_sh        <= a;
            b_sh        <= b;
            carry       <= cin;
            bit_cnt     <= '0;
            state       <= SHIFT;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end

        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          // Sum bits enter at the MSB so the LSB-first result lands aligned.
          sum_sh  <= (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
          carry   <= fa_co;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            state        <= DONE;
            cout         <= fa_co;
            ovf          <= carry ^ fa_co;
            result_valid <= 1'b1;
          end
        end

        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          start_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       sv8, sr8, rv8, rr8, cin8, cout8, ovf8, busy8;
  logic [7:0] a8, b8, sum8;

  logic       sv1, sr1, rv1, rr1, cin1, cout1, ovf1, busy1;
  logic [0:0] a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .cin(cin8), .result_valid(rv8), .result_ready(rr8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .cin(cin1), .result_valid(rv1), .result_ready(rr1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum} for a W-bit add, from integer sum and sign rule.
  function automatic logic [33:0] ref_add(input int w, input longint ua, input longint ub, input logic c);
    longint total, mask, s;
    logic   sa, sb, ss, co, ov;
    mask  = (longint'(1) << w) - 1;
    total = ua + ub + longint'(c);
    s     = total & mask;
    co    = ((total >> w) & 1) != 0;
    sa    = ((ua >> (w - 1)) & 1) != 0;
    sb    = ((ub >> (w - 1)) & 1) != 0;
    ss    = ((s  >> (w - 1)) & 1) != 0;
    ov    = (sa == sb) && (ss != sa);
    return {ov, co, s[31:0]};
  endfunction

  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input int hold, input string tag);
    logic [33:0] e;
    int          wait_cnt, lat;
    e = ref_add(8, longint'(ta), longint'(tb_), tc);
    wait_cnt = 0;
    while (sr8 !== 1'b1 && wait_cnt < 20) begin step(); wait_cnt++; end
    check({tag, ".ready"}, sr8, 1'b1);
    a8 = ta; b8 = tb_; cin8 = tc; sv8 = 1'b1; rr8 = (hold == 0);
    step();
    sv8 = 1'b0;
    check({tag, ".busy"}, {busy8, sr8, rv8}, 3'b100);
    lat = 0;
    while (rv8 !== 1'b1 && lat < 40) begin step(); lat++; end
    check({tag, ".latency"}, lat, 8);
    check({tag, ".sum"}, sum8, e[7:0]);
    check({tag, ".cout_ovf"}, {cout8, ovf8}, {e[32], e[33]});
    if (hold > 0) begin
      sv8 = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, ".hold"}, {rv8, sr8, busy8, cout8, ovf8, sum8},
              {3'b101, e[32], e[33], e[7:0]});
      end
      sv8 = 1'b0;
      rr8 = 1'b1;
    end
    step();
    check({tag, ".idle"}, {rv8, sr8, busy8, sum8}, {3'b010, e[7:0]});
  endtask

  task automatic do_op1(input logic ta, input logic tb_, input logic tc, input string tag);
    logic [33:0] e;
    e = ref_add(1, longint'(ta), longint'(tb_), tc);
    a1[0] = ta; b1[0] = tb_; cin1 = tc; sv1 = 1'b1; rr1 = 1'b1;
    step();
    sv1 = 1'b0;
    check({tag, ".shift"}, {rv1, busy1}, 2'b01);
    step();
    check({tag, ".result"}, {rv1, sum1, cout1, ovf1}, {1'b1, e[0], e[32], e[33]});
    step();
    check({tag, ".idle"}, {rv1, sr1, busy1}, 3'b010);
  endtask

  initial begin
    logic [33:0] exp_q[$];
    logic [33:0] e;
    int          last_acc, n_acc, seen_rv;
    logic        acc;

    rst_n = 1'b0;
    sv8 = 1'b0; rr8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    sv1 = 1'b0; rr1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
    step(); step();
    check("reset8", {sr8, rv8, busy8, sum8, cout8, ovf8}, {3'b100, 8'h00, 2'b00});
    check("reset1", {sr1, rv1, busy1, sum1, cout1, ovf1}, {3'b100, 1'b0, 2'b00});
    rst_n = 1'b1;
    step();

    do_op8(8'd3,   8'd5, 1'b0, 0, "add_3_5");
    do_op8(8'd255, 8'd1, 1'b0, 0, "add_255_1");
    do_op8(8'd127, 8'd1, 1'b0, 0, "add_127_1");
    do_op8(8'h80,  8'h80, 1'b1, 5, "backpressure");

    for (int i = 0; i < 8; i++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");

    // Reset in the middle of an operation.
    a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1; sv8 = 1'b1;
    step();
    sv8 = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midreset.state", {sr8, rv8, busy8, sum8, cout8, ovf8}, {3'b100, 8'h00, 2'b00});
    seen_rv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rv8 === 1'b1) seen_rv++;
    end
    check("midreset.no_pulse", seen_rv, 0);
    do_op8(8'd1, 8'd1, 1'b0, 0, "after_reset");

    // Back-to-back with start_valid held high.
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    sv8 = 1'b1; rr8 = 1'b1;
    last_acc = -1; n_acc = 0;
    for (int c = 0; c < 80 && n_acc < 5; c++) begin
      acc = (sr8 === 1'b1);
      if (acc) exp_q.push_back(ref_add(8, longint'(a8), longint'(b8), cin8));
      step();
      if (acc) begin
        if (last_acc >= 0) check("b2b.spacing", c - last_acc, 10);
        last_acc = c;
        n_acc++;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      if (rv8 === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("b2b.unexpected_result", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("b2b.result", {sum8, cout8, ovf8}, {e[7:0], e[32], e[33]});
        end
      end
    end
    check("b2b.accepts", n_acc, 5);
    sv8 = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step();
      if (rv8 === 1'b1) begin
        e = exp_q.pop_front();
        check("b2b.drain", {sum8, cout8, ovf8}, {e[7:0], e[32], e[33]});
      end
    end
    check("b2b.all_results", exp_q.size(), 0);

    // WIDTH=1 instance: directed case then every operand combination.
    do_op1(1'b1, 1'b1, 1'b1, "w1_111");
    for (int i = 0; i < 8; i++)
      do_op1(1'(i >> 2), 1'(i >> 1), 1'(i), "w1_all");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 1..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start_valid, input, 1 bit: the requester offers an operation.
REQ-005 SHALL have port start_ready, output, 1 bit: the controller can accept an operation.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, sampled on the start handshake.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, sampled on the start handshake.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, sampled on the start handshake.
REQ-009 SHALL have port result_valid, output, 1 bit: sum, cout and ovf are valid.
REQ-010 SHALL have port result_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH bits: the value of (a+b+cin) mod 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-013 SHALL have port ovf, output, 1 bit: signed overflow, equal to carry into the MSB XOR cout.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 SHALL add bit-serially, LSB first, using one 1-bit full-add cell per cycle with a registered carry.
REQ-016 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-017 In IDLE, start_ready SHALL be 1; on start_valid&start_ready, SHALL load the a and b shift registers and the carry register (from cin), clear bit_cnt, and go to SHIFT.
REQ-018 In SHIFT, each cycle SHALL add a_sh[0], b_sh[0] and carry; shift the sum bit in at the MSB of sum_sh; shift a_sh and b_sh right; update carry; and increment bit_cnt.
REQ-019 When bit_cnt==WIDTH-1 in SHIFT, the FSM SHALL go to DONE on that edge, latching cout from the final carry and ovf from (carry in XOR carry out) of that bit.
REQ-020 Latency SHALL be exactly WIDTH cycles from the accepting edge to the first cycle of result_valid=1; throughput SHALL be one operation per WIDTH+2 cycles at best.
REQ-021 In DONE, result_valid SHALL be 1, and sum, cout and ovf SHALL hold stable until result_ready=1.
REQ-022 On result_valid&result_ready the FSM SHALL go to IDLE; if result_ready is already high, DONE SHALL last exactly one cycle.
REQ-023 start_ready SHALL be 0 in SHIFT and DONE; start_valid SHALL be ignored there and no operation queued.
REQ-024 For WIDTH=1, SHIFT SHALL last exactly one cycle.
REQ-025 sum SHALL hold its last result while in IDLE; it SHALL be don't-care during SHIFT.
REQ-026 The bit_cnt width SHALL be $clog2(WIDTH+1); bit_cnt SHALL never wrap within one operation.

Reset
REQ-027 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and start_ready=1, result_valid=0, busy=0, sum=0, cout=0 and ovf=0 from the next cycle.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no result_valid pulse.
REQ-029 Reset SHALL take priority over every handshake in the same cycle.

Structure
REQ-030 The FSM state enum (IDLE/SHIFT/DONE) SHALL live in shared package serial_add_pkg, together with the WIDTH range constants.
REQ-031 The combinational 1-bit sum/carry SHALL be one sub-module, full_add_cell (inputs a, b, ci; outputs sum, co).

Verification
REQ-032 W=8, a=3, b=5, cin=0, result_ready=1 -> result_valid rises 8 cycles after accept; sum=8, cout=0, ovf=0.
REQ-033 W=8, a=255, b=1, cin=0 -> sum=0, cout=1, ovf=0; a=127, b=1 -> sum=128, cout=0, ovf=1.
REQ-034 Backpressure: result_ready=0 for 5 cycles in DONE -> result_valid, sum, cout and ovf stable for all 5 cycles; start_ready=0 throughout.
REQ-035 Reset mid-op: rst_n=0 at bit 4 of a W=8 operation -> IDLE next cycle; no result_valid pulse; a new a=1, b=1 then yields sum=2.
REQ-036 Back-to-back: start_valid held high, result_ready=1 -> accepts spaced exactly WIDTH+2 cycles apart; start_valid during SHIFT is never accepted.
REQ-037 W=1, a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0, result_valid 1 cycle after accept.
